hc04_filt_inv: RTL and testbench
================================

# hc04_filt_inv

Parametrised, registered successor to the hex inverter pad macro: a CH-channel logic-level bank that synchronises each asynchronous input, rejects glitches shorter than a programmable number of clocks, and applies a per-channel run-time polarity mask (invert or pass) before driving registered, output-enabled outputs. It also reports per-channel filtered edge pulses and counts rejected glitches. It sits directly behind the input pads and feeds the core logic and output pads.

## Interface
Parameters:
- CH, 6, channel count (1..32)
- SYNC_STAGES, 2, synchroniser depth per channel (≥2)
- FILT_CNT, 8, consecutive stable cycles needed to accept a new level (1..255); FILT_W = clog2(FILT_CNT+1)
- GCNT_W, 8, width of the rejected-glitch counter

Ports:
- clk, in, 1, the single clock domain
- rst_n, in, 1, reset, asynchronous, active-low
- A, in, CH, asynchronous channel inputs
- mask_in, in, CH, polarity mask (1 = invert, 0 = pass)
- cfg_load, in, 1, one-cycle strobe that loads mask_in into the active mask
- oe, in, 1, output enable (0 forces Y to zero)
- gcnt_clr, in, 1, clears the glitch counter
- Y, out, CH, registered output
- rise, out, CH, one-cycle pulse on an accepted 0→1 filtered transition
- fall, out, CH, one-cycle pulse on an accepted 1→0 filtered transition
- gcnt, out, GCNT_W, saturating count of rejected glitches, all channels combined

## Operation
- Reset (rst_n low, asynchronous): sync chains, filtered state s, and per-channel counters c go to 0. The active mask goes to all ones, which is the default inverter behaviour. Y, rise, fall and gcnt go to 0.
- Synchroniser: per channel, a SYNC_STAGES-deep flop chain. Its output is a_s[i].
- Filter, per channel and per clock:
  - If a_s == s: c <= 0.
  - Else, if c == FILT_CNT-1: s <= a_s, c <= 0, and the edge is accepted.
  - Else: c <= c+1.
- Glitch: a channel whose c is nonzero sees a_s == s again (a mismatch run was abandoned). Each such event increments gcnt by one. If several channels do so in the same cycle, gcnt increments by the number of channels, saturating at 2^GCNT_W-1 with no wrap.
- gcnt_clr: gcnt <= 0. This takes priority over increments in the same cycle.
- Mask: cfg_load at edge k updates the active mask at edge k. Y uses the new mask from edge k+1. mask_in is ignored when cfg_load is low.
- Output register, every clock:
  - Y <= oe ? (s ^ mask) : 0.
  - rise <= accepted & new s = 1.
  - fall <= accepted & new s = 0.
  - rise and fall are based on the filtered state before the mask and do not depend on oe.
- Simultaneous events are independent:
  - A cfg_load in the same cycle as an accepted edge yields Y = new s ^ new mask one edge later.
  - An oe change in the same cycle behaves the same way.

## Timing
- Latency: a level change on A first sampled at edge 0 (and held) changes s at edge SYNC_STAGES+FILT_CNT−1. Y, rise and fall change at edge SYNC_STAGES+FILT_CNT. With defaults this is edge 10.
- A pulse lasting fewer than FILT_CNT synchronised cycles never changes s or Y. It produces exactly one gcnt increment.
- rise and fall are exactly one cycle wide. Back-to-back accepted edges are at least FILT_CNT cycles apart.
- cfg_load takes effect on Y one edge after the strobe. oe also takes effect on Y one edge after it changes.
- Reset asserted mid-filter discards the partial count. After release, Y reflects mask^0 one edge later, provided oe is high.
- No combinational path exists from any input to any output.

## Test plan
- Reset then default config: release rst_n with A=0, oe=1. Y=6'h3F one edge later. rise=fall=0 and gcnt=0.
- Latency: step A[0] 0→1 and hold. Y[0] falls to 0 and rise[0] pulses exactly 10 edges after the first sample. No other channel changes.
- Glitch rejection: pulse A[3] high for 5 cycles. Y is unchanged and gcnt=1. Then pulse all six channels for 3 cycles simultaneously. gcnt=7.
- Mask and oe: cfg_load with mask_in=6'h2A while s=0. Y=6'h2A on the next edge. Drive oe=0: Y=0 on the next edge while rise and fall still pulse on accepted edges.
- Saturation and clear: generate 300 glitches with GCNT_W=8. gcnt holds 255. Assert gcnt_clr in the same cycle as a glitch. gcnt=0.
- Reset mid-operation: assert rst_n low 5 cycles into a 8-cycle accept window. All outputs go to 0 immediately. After release, no rise pulse until a full 10-edge window elapses.

Source files
------------

// File: rtl/hc04_filt_inv.sv
// Registered, glitch-filtered inverter bank: synchronise each input, accept a level only
// after FILT_CNT stable clocks, then apply a run-time polarity mask behind an output enable.
module hc04_filt_inv #(
   parameter int CH          = 6,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CNT    = 8,
   parameter int GCNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH-1:0]     A,
   input  logic [CH-1:0]     mask_in,
   input  logic              cfg_load,
   input  logic              oe,
   input  logic              gcnt_clr,
   output logic [CH-1:0]     Y,
   output logic [CH-1:0]     rise,
   output logic [CH-1:0]     fall,
   output logic [GCNT_W-1:0] gcnt
);

   localparam int FILT_W = $clog2(FILT_CNT + 1);
   localparam logic [FILT_W-1:0] LIM = FILT_W'(FILT_CNT - 1);
   localparam logic [FILT_W-1:0] ONE = FILT_W'(1);
   // Sum width leaves headroom for up to 32 simultaneous glitches on top of a full counter.
   localparam int SW = GCNT_W + 6;
   localparam logic [SW-1:0] GMAX = SW'((64'd1 << GCNT_W) - 64'd1);

   logic [CH-1:0]     sync_reg [SYNC_STAGES];
   logic [CH-1:0]     a_s;
   logic [CH-1:0]     s_reg, s_next, s_prev_reg;
   logic [CH-1:0]     mask_reg;
   logic [CH-1:0]     glitch;
   logic [FILT_W-1:0] c_reg  [CH];
   logic [FILT_W-1:0] c_next [CH];
   logic [GCNT_W-1:0] gcnt_reg, gcnt_next;
   logic [CH-1:0]     y_reg, rise_reg, fall_reg;
   logic [SW-1:0]     gsum, gtot;

   assign a_s = sync_reg[SYNC_STAGES-1];

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_chan
         logic mism;
         logic at_lim;
         assign mism       = a_s[gi] ^ s_reg[gi];
         assign at_lim     = (c_reg[gi] == LIM);
         assign s_next[gi] = (mism && at_lim) ? a_s[gi] : s_reg[gi];
         assign c_next[gi] = (!mism || at_lim) ? '0 : c_reg[gi] + ONE;
         // A mismatch run that ends without reaching the limit is a rejected glitch.
         assign glitch[gi] = !mism && (c_reg[gi] != '0);
      end
   endgenerate

   always_comb begin
      gsum = '0;
      for (int k = 0; k < CH; k++) begin
         gsum = gsum + SW'(glitch[k]);
      end
      gtot = SW'(gcnt_reg) + gsum;
      if (gcnt_clr) begin
         gcnt_next = '0;
      end else if (gtot > GMAX) begin
         gcnt_next = GMAX[GCNT_W-1:0];
      end else begin
         gcnt_next = gtot[GCNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_reg[k] <= '0;
         end
         for (int k = 0; k < CH; k++) begin
            c_reg[k] <= '0;
         end
         s_reg      <= '0;
         s_prev_reg <= '0;
         mask_reg   <= '1;
         gcnt_reg   <= '0;
         y_reg      <= '0;
         rise_reg   <= '0;
         fall_reg   <= '0;
      end else begin
         sync_reg[0] <= A;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_reg[k] <= sync_reg[k-1];
         end
         for (int k = 0; k < CH; k++) begin
            c_reg[k] <= c_next[k];
         end
         s_reg      <= s_next;
         s_prev_reg <= s_reg;
         if (cfg_load) begin
            mask_reg <= mask_in;
         end
         gcnt_reg <= gcnt_next;
         // Outputs trail the filtered state by one edge so mask, oe and edges line up.
         y_reg    <= oe ? (s_reg ^ mask_reg) : '0;
         rise_reg <= s_reg & ~s_prev_reg;
         fall_reg <= ~s_reg & s_prev_reg;
      end
   end

   assign Y    = y_reg;
   assign rise = rise_reg;
   assign fall = fall_reg;
   assign gcnt = gcnt_reg;

endmodule

// File: tb/tb_hc04_filt_inv.sv
// Bench for hc04_filt_inv: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the filter rules.
module tb_hc04_filt_inv;

   localparam int CH   = 6;
   localparam int SS   = 2;
   localparam int FC   = 8;
   localparam int GW   = 8;
   localparam int GMAX = (1 << GW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH-1:0] A = '0;
   logic [CH-1:0] mask_in = '0;
   logic          cfg_load = 1'b0;
   logic          oe = 1'b1;
   logic          gcnt_clr = 1'b0;
   logic [CH-1:0] Y, rise, fall;
   logic [GW-1:0] gcnt;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   hc04_filt_inv #(.CH(CH), .SYNC_STAGES(SS), .FILT_CNT(FC), .GCNT_W(GW)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .mask_in(mask_in), .cfg_load(cfg_load),
      .oe(oe), .gcnt_clr(gcnt_clr), .Y(Y), .rise(rise), .fall(fall), .gcnt(gcnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: A is seen SS edges late; each channel counts how long the
   // delayed input has disagreed with its accepted level.
   logic [CH-1:0] m_sync [SS];
   logic [CH-1:0] m_s, m_mask, m_y, m_rise, m_fall, m_pr, m_pf;
   int            m_c [CH];
   int            m_g;

   task automatic model_reset();
      for (int k = 0; k < SS; k++) m_sync[k] = '0;
      for (int i = 0; i < CH; i++) m_c[i] = 0;
      m_s = '0; m_mask = '1; m_y = '0; m_rise = '0; m_fall = '0;
      m_pr = '0; m_pf = '0; m_g = 0;
   endtask

   task automatic model_step();
      logic [CH-1:0] as;
      int            ng;
      m_y    = oe ? (m_s ^ m_mask) : '0;
      m_rise = m_pr;
      m_fall = m_pf;
      m_pr   = '0;
      m_pf   = '0;
      if (cfg_load) m_mask = mask_in;
      as = m_sync[SS-1];
      ng = 0;
      for (int i = 0; i < CH; i++) begin
         if (as[i] == m_s[i]) begin
            if (m_c[i] > 0) ng++;
            m_c[i] = 0;
         end else if (m_c[i] + 1 == FC) begin
            m_s[i] = as[i];
            m_c[i] = 0;
            if (as[i]) m_pr[i] = 1'b1;
            else       m_pf[i] = 1'b1;
         end else begin
            m_c[i]++;
         end
      end
      if (gcnt_clr) m_g = 0;
      else          m_g = (m_g + ng > GMAX) ? GMAX : m_g + ng;
      for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = A;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("mdl_Y", Y, m_y);
         check_eq("mdl_rise", rise, m_rise);
         check_eq("mdl_fall", fall, m_fall);
         check_eq("mdl_gcnt", gcnt, m_g);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      tick(3);
      chk_en = 1'b1;
      check_eq("rst_Y", Y, 0);
      check_eq("rst_gcnt", gcnt, 0);
      rst_n = 1'b1;
      tick(1);
      check_eq("post_rst_Y", Y, 6'h3F);
      check_eq("post_rst_rise", rise, 0);
      check_eq("post_rst_fall", fall, 0);

      // Latency of one accepted edge
      A = 6'h01;
      tick(10);
      check_eq("lat_Y_early", Y, 6'h3F);
      check_eq("lat_rise_early", rise, 0);
      tick(1);
      check_eq("lat_Y", Y, 6'h3E);
      check_eq("lat_rise", rise, 6'h01);
      tick(1);
      check_eq("lat_rise_width", rise, 0);

      // Glitch rejection
      A = 6'h09;
      tick(5);
      A = 6'h01;
      tick(12);
      check_eq("glitch_gcnt1", gcnt, 1);
      check_eq("glitch_Y", Y, 6'h3E);
      A = 6'h3E;
      tick(3);
      A = 6'h01;
      tick(12);
      check_eq("glitch_gcnt7", gcnt, 7);
      check_eq("glitch_Y2", Y, 6'h3E);
      A = 6'h00;
      tick(14);
      check_eq("settle_Y", Y, 6'h3F);

      // Mask load and output enable
      mask_in = 6'h2A;
      cfg_load = 1'b1;
      tick(1);
      cfg_load = 1'b0;
      mask_in = 6'h15;
      check_eq("mask_Y_old", Y, 6'h3F);
      tick(1);
      check_eq("mask_Y_new", Y, 6'h2A);
      oe = 1'b0;
      tick(1);
      check_eq("oe_Y0", Y, 0);
      A = 6'h02;
      for (int i = 0; i < 20 && rise == '0; i++) tick(1);
      check_eq("oe_rise", rise, 6'h02);
      check_eq("oe_rise_Y", Y, 0);
      A = 6'h00;
      for (int i = 0; i < 20 && fall == '0; i++) tick(1);
      check_eq("oe_fall", fall, 6'h02);
      oe = 1'b1;
      tick(1);
      check_eq("oe_back_Y", Y, 6'h2A);

      // Saturation and clear
      repeat (50) begin
         A = 6'h3F;
         tick(2);
         A = 6'h00;
         tick(2);
      end
      tick(4);
      check_eq("sat_gcnt", gcnt, 255);
      check_eq("sat_Y", Y, 6'h2A);
      A = 6'h3F;
      tick(2);
      A = 6'h00;
      tick(2);
      gcnt_clr = 1'b1;
      tick(1);
      gcnt_clr = 1'b0;
      check_eq("clr_gcnt", gcnt, 0);
      tick(4);
      check_eq("clr_gcnt_hold", gcnt, 0);

      // Reset mid-window discards the partial count
      A = 6'h10;
      tick(7);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_Y", Y, 0);
      check_eq("midrst_rise", rise, 0);
      tick(2);
      rst_n = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick(1);
         if (k == 1) check_eq("midrst_Y_rel", Y, 6'h3F);
         if (k <= 10) check_eq("midrst_no_rise", rise, 0);
         else         check_eq("midrst_rise_full", rise, 6'h10);
      end

      // Randomized traffic against the model
      for (int n = 0; n < 2500; n++) begin
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 11) == 0) A[i] = ~A[i];
         end
         cfg_load = ($urandom_range(0, 15) == 0);
         mask_in  = CH'($urandom);
         if ($urandom_range(0, 19) == 0) oe = ~oe;
         gcnt_clr = ($urandom_range(0, 99) == 0);
         tick(1);
      end
      cfg_load = 1'b0;
      gcnt_clr = 1'b0;
      tick(2);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
